// File: rtl/gcd_rr_sched.sv
// Round-robin front end sharing one subtractive GCD engine among NREQ requesters, with
// zero-operand bypass, stale-done masking, run timeout and a 1-entry tagged response buffer.
module gcd_rr_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 36,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic                      eng_start,
    output logic [WIDTH-1:0]          eng_a,
    output logic [WIDTH-1:0]          eng_b,
    input  logic                      eng_done,
    input  logic [WIDTH-1:0]          eng_res,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]          rsp_res,
    output logic                      rsp_err,
    output logic                      busy
);
    localparam int unsigned IdW  = $clog2(NREQ);
    localparam int unsigned CntW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StLaunch, StSettle, StRun} state_e;

    state_e            state_q, state_d;
    logic [IdW-1:0]    ptr_q, ptr_d;
    logic [IdW-1:0]    tag_q, tag_d;
    logic [WIDTH-1:0]  eng_a_q, eng_a_d;
    logic [WIDTH-1:0]  eng_b_q, eng_b_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IdW-1:0]    rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]  rsp_res_q, rsp_res_d;
    logic              rsp_err_q, rsp_err_d;

    logic [WIDTH-1:0]  a_arr [NREQ];
    logic [WIDTH-1:0]  b_arr [NREQ];
    logic [IdW:0]      idx_sum;
    logic [IdW-1:0]    cand;
    logic              cand_found;
    logic [WIDTH-1:0]  cand_a, cand_b;
    logic              cand_byp;
    logic              buf_free;
    logic              grant_ok;
    logic              load;
    logic [IdW-1:0]    load_id;
    logic [WIDTH-1:0]  load_res;
    logic              load_err;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = req_a[i*WIDTH +: WIDTH];
            b_arr[i] = req_b[i*WIDTH +: WIDTH];
        end
    end

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        cand_found = 1'b0;
        cand       = '0;
        idx_sum    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_sum = {1'b0, ptr_q} + (IdW+1)'(k);
            if (idx_sum >= (IdW+1)'(NREQ)) begin
                idx_sum = idx_sum - (IdW+1)'(NREQ);
            end
            if (!cand_found && req_valid[idx_sum[IdW-1:0]]) begin
                cand_found = 1'b1;
                cand       = idx_sum[IdW-1:0];
            end
        end
    end

    assign cand_a   = a_arr[cand];
    assign cand_b   = b_arr[cand];
    assign cand_byp = (cand_a == '0) || (cand_b == '0);
    assign buf_free = !rsp_valid_q || rsp_ready;
    // A bypass that cannot land in the buffer blocks arbitration entirely this cycle.
    assign grant_ok = (state_q == StIdle) && cand_found && (!cand_byp || buf_free);
    assign req_ready = grant_ok ? (NREQ'(1) << cand) : '0;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        tag_d    = tag_q;
        eng_a_d  = eng_a_q;
        eng_b_d  = eng_b_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        load_id  = tag_q;
        load_res = '0;
        load_err = 1'b0;
        case (state_q)
            StIdle: begin
                if (grant_ok) begin
                    ptr_d = (cand == IdW'(NREQ-1)) ? '0 : cand + 1'b1;
                    if (cand_byp) begin
                        load     = 1'b1;
                        load_id  = cand;
                        load_res = cand_a | cand_b;
                    end else begin
                        tag_d   = cand;
                        eng_a_d = cand_a;
                        eng_b_d = cand_b;
                        state_d = StLaunch;
                    end
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StSettle;
            end
            StSettle: begin
                state_d = StRun;
            end
            StRun: begin
                // Done has priority over timeout; counter freezes while the buffer is full.
                if (eng_done) begin
                    if (buf_free) begin
                        load     = 1'b1;
                        load_res = eng_res;
                        state_d  = StIdle;
                    end
                end else if (cnt_q == CntW'(TIMEOUT-1)) begin
                    if (buf_free) begin
                        load     = 1'b1;
                        load_err = 1'b1;
                        state_d  = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_id_d    = rsp_id_q;
        rsp_res_d   = rsp_res_q;
        rsp_err_d   = rsp_err_q;
        if (load) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = load_id;
            rsp_res_d   = load_res;
            rsp_err_d   = load_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            tag_q       <= '0;
            eng_a_q     <= '0;
            eng_b_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            tag_q       <= tag_d;
            eng_a_q     <= eng_a_d;
            eng_b_q     <= eng_b_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_res_q   <= rsp_res_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign eng_start = (state_q == StLaunch);
    assign eng_a     = eng_a_q;
    assign eng_b     = eng_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_gcd_rr_sched.sv
// Directed bench for gcd_rr_sched: vector table of single jobs plus hand-written fairness,
// stall/backpressure, timeout and mid-job reset sequences against a behavioural GCD engine.
module tb_gcd_rr_sched;
    localparam int NREQ = 4;
    localparam int W    = 36;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ-1:0]   req_ready;
    logic              eng_start;
    logic [W-1:0]      eng_a, eng_b;
    logic              eng_done;
    logic [W-1:0]      eng_res;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_res;
    logic              rsp_err;
    logic              busy;

    always #5 clk = ~clk;

    gcd_rr_sched #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
        .eng_done(eng_done), .eng_res(eng_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_err(rsp_err), .busy(busy)
    );

    int total = 0;
    int bad   = 0;
    int starts = 0;
    int oh_bad = 0;

    // Behavioural engine: result after e_lat cycles; optionally keeps the old done/result
    // visible through the settle cycle, or never finishes.
    int         e_lat = 1;
    bit         e_stale = 1'b0;
    bit         e_never = 1'b0;
    int         e_cd;
    logic       e_busy;
    logic [W-1:0] e_a, e_b;

    function automatic logic [W-1:0] gcd_f(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            eng_done <= 1'b0;
            eng_res  <= '0;
            e_busy   <= 1'b0;
            e_cd     <= 0;
        end else if (eng_start) begin
            e_a    <= eng_a;
            e_b    <= eng_b;
            e_cd   <= e_lat;
            e_busy <= !e_never;
            if (!e_stale) eng_done <= 1'b0;
        end else if (e_busy) begin
            if (e_cd <= 1) begin
                eng_done <= 1'b1;
                eng_res  <= gcd_f(e_a, e_b);
                e_busy   <= 1'b0;
            end else begin
                e_cd <= e_cd - 1;
            end
        end
    end

    always @(posedge clk) if (!reset && eng_start) starts++;
    always @(negedge clk) if (!reset && ($countones(req_ready) > 1)) oh_bad++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_valid[idx]    = 1'b1;
    endtask

    // Issue one job from requester idx and check grant, launch, latency and response.
    task automatic run_job(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_res, input bit exp_err, input bit byp,
                           input int exp_lat);
        int n;
        int s0;
        @(negedge clk);
        set_req(idx, a, b);
        #1;
        n = 0;
        while (req_ready == '0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("grant", req_ready, 64'(1) << idx);
        s0 = starts;
        n  = 0;
        do begin
            @(negedge clk);
            if (n == 0) req_valid = '0;
            #1;
            n++;
            if (n == 1 && !byp) begin
                chk("launch_start", eng_start, 1);
                chk("launch_a", eng_a, a);
                chk("launch_b", eng_b, b);
            end
        end while (!rsp_valid && n < 30);
        chk("latency", n, exp_lat);
        chk("rsp_res", rsp_res, exp_res);
        chk("rsp_id", rsp_id, idx);
        chk("rsp_err", rsp_err, exp_err);
        chk("start_count", starts - s0, byp ? 0 : 1);
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_req_ready"}, req_ready, 0);
        chk({pfx, "_eng_start"}, eng_start, 0);
        chk({pfx, "_eng_a"}, eng_a, 0);
        chk({pfx, "_eng_b"}, eng_b, 0);
        chk({pfx, "_rsp_valid"}, rsp_valid, 0);
        chk({pfx, "_rsp_id"}, rsp_id, 0);
        chk({pfx, "_rsp_res"}, rsp_res, 0);
        chk({pfx, "_rsp_err"}, rsp_err, 0);
        chk({pfx, "_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        int           idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        bit           byp;
        bit           stale;
        int           lat;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int n;
        vecs[0] = '{0, 36'd48,          36'd18,  36'd6,   1'b0, 1'b0, 1};
        vecs[1] = '{1, 36'd35,          36'd21,  36'd7,   1'b0, 1'b1, 1};
        vecs[2] = '{2, 36'd0,           36'd45,  36'd45,  1'b1, 1'b0, 0};
        vecs[3] = '{3, 36'd0,           36'd0,   36'd0,   1'b1, 1'b0, 0};
        vecs[4] = '{3, 36'd100,         36'd75,  36'd25,  1'b0, 1'b0, 3};
        vecs[5] = '{1, 36'd17,          36'd5,   36'd1,   1'b0, 1'b0, 2};
        vecs[6] = '{2, 36'd12,          36'd0,   36'd12,  1'b1, 1'b0, 0};
        vecs[7] = '{0, 36'hF_FFFF_FFFF, 36'd3,   36'd3,   1'b0, 1'b0, 1};
        vecs[8] = '{2, 36'd1000,        36'd375, 36'd125, 1'b0, 1'b1, 1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;

        foreach (vecs[i]) begin
            e_lat   = vecs[i].lat;
            e_stale = vecs[i].stale;
            e_never = 1'b0;
            run_job(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, vecs[i].byp,
                    vecs[i].byp ? 1 : 3 + vecs[i].lat);
        end
        e_stale = 1'b0;

        // Fairness: all requesters continuously valid with bypass operands
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_req(i, 36'd0, W'(i + 1));
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_grant", req_ready, 64'(1) << (k % NREQ));
            if (k > 0) begin
                chk("rr_res", rsp_res, ((k - 1) % NREQ) + 1);
                chk("rr_id", rsp_id, (k - 1) % NREQ);
            end
            @(negedge clk);
        end
        req_valid = '0;

        // Stalled bypass blocks arbitration; engine job done while buffer full waits in RUN
        do_reset();
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(0, 36'd0, 36'd5);
        #1;
        chk("bp_grant0", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("bp_full_valid", rsp_valid, 1);
        chk("bp_full_res", rsp_res, 5);
        set_req(1, 36'd0, 36'd9);
        set_req(2, 36'd9, 36'd6);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_no_grant", req_ready, 0);
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        e_lat = 1;
        #1;
        chk("bp_grant2", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        repeat (12) @(negedge clk);
        #1;
        chk("bp_busy", busy, 1);
        chk("bp_hold_valid", rsp_valid, 1);
        chk("bp_hold_res", rsp_res, 5);
        chk("bp_hold_id", rsp_id, 0);
        chk("bp_hold_err", rsp_err, 0);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_new_valid", rsp_valid, 1);
        chk("bp_new_res", rsp_res, 3);
        chk("bp_new_id", rsp_id, 2);
        chk("bp_new_err", rsp_err, 0);
        @(negedge clk);
        #1;
        chk("bp_drained", rsp_valid, 0);
        chk("bp_idle", busy, 0);

        // Timeout: engine never finishes, TIMEOUT=8
        e_never = 1'b1;
        run_job(3, 36'd8, 36'd4, 36'd0, 1'b1, 1'b0, 11);

        // Reset in RUN: job discarded, no response afterwards
        @(negedge clk);
        set_req(0, 36'd20, 36'd8);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        #1;
        chk("mid_in_run", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_zero("rst_mid");
        reset = 1'b0;
        n = 0;
        repeat (15) begin
            @(negedge clk);
            #1;
            if (rsp_valid) n++;
        end
        chk("rst_no_rsp", n, 0);
        chk("rst_no_busy", busy, 0);

        chk("onehot", oh_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
